fetch_stage: RTL and testbench

Parametrised instruction-fetch stage: owns the program counter, issues sequential instruction-memory requests over a valid/ready interface, and buffers returned instructions with their PCs in a small FIFO toward decode. It supports control-flow redirects, discarding wrong-path responses that are still in flight. It sits between the instruction memory and the decode stage, replacing the single-cycle PC/increment/memory fetch path.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: instruction width, PC step and the
// {pc, instr} entry buffered between instruction memory and decode.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_STEP = 4;
   localparam int unsigned DEF_XLEN = 32;
   localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = '0;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [INSTR_W-1:0]  instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push is visible on dout the cycle after (no bypass).
// Pushes while full and pops while empty are ignored; callers must respect count/full/empty.
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues sequential imem requests, buffers {pc, instr} for decode.
// Response to instr_valid_o is one cycle; requests are credit-limited so every kept response has a slot.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN       = DEF_XLEN,
   parameter int unsigned     FIFO_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
   output logic               imem_req_valid_o,
   input  logic               imem_req_ready_i,
   output logic [XLEN-1:0]    imem_req_addr_o,
   input  logic               imem_rsp_valid_i,
   input  logic [INSTR_W-1:0] imem_rsp_data_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [XLEN-1:0]    instr_pc_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic            en_q;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   live_cnt;
   logic [CW:0]     credit_used;
   logic [CW-1:0]   fifo_count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            req_fire;
   logic            rsp_take;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redirect_pc;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   // Live requests (not destined for the drop) plus buffered entries must fit in the FIFO.
   assign live_cnt         = out_cnt_q - drop_cnt_q;
   assign credit_used      = {1'b0, live_cnt} + {1'b0, fifo_count};
   assign imem_req_valid_o = en_q && (out_cnt_q < CW'(FIFO_DEPTH))
                                  && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr_o  = fetch_pc_q;

   assign req_fire    = imem_req_valid_o && imem_req_ready_i;
   assign rsp_take    = imem_rsp_valid_i && (out_cnt_q != '0);
   assign redirect_pc = redirect_pc_i & ~XLEN'(3);
   assign pop         = instr_valid_o && instr_ready_i && !redirect_i;
   assign push_entry  = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_cnt_d = drop_cnt_q;
      push       = 1'b0;
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_take);
      if (redirect_i) begin
         // Everything still outstanding after this cycle, including a request
         // accepted right now, belongs to the old path.
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         drop_cnt_d = out_cnt_d;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         if (rsp_take) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
               push     = 1'b1;
               rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q       <= 1'b0;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         en_q       <= 1'b1;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   sync_fifo #(
      .DATA_W ($bits(fetch_entry_t)),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_i),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign instr_valid_o = !fifo_empty;
   assign instr_o       = head_entry.instr;
   assign instr_pc_o    = head_entry.pc;

   a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid_i |-> (out_cnt_q != '0));
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with programmable latency and an
// instruction-stream reference (expected PC sequence restarted on each redirect).
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst_n;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;

   fetch_stage #(
      .XLEN       (32),
      .FIFO_DEPTH (4),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk              (clk),
      .rst              (rst_n),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       memq[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          nreq = 0;
   int          npop = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          rdy_pct = 100;
   int          irdy_pct = 100;
   logic [31:0] exp_req;
   logic [31:0] exp_pc;
   bit          post_redir = 1'b0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hC3A5_0F1E;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input bit redir, input logic [31:0] rpc);
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = memf(memq[0].addr);
         void'(memq.pop_front());
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = '0;
      end
      imem_req_ready_i = (int'($urandom_range(99)) < rdy_pct);
      instr_ready_i    = (int'($urandom_range(99)) < irdy_pct);
      redirect_i       = redir;
      redirect_pc_i    = rpc;
      #1;
      if (post_redir) chk("flush_after_redirect", 32'(instr_valid_o), 32'd0);
      if (imem_req_valid_o && imem_req_ready_i) begin
         chk("req_addr", imem_req_addr_o, exp_req);
         memq.push_back('{addr: imem_req_addr_o,
                          due: cyc + int'($urandom_range(lat_max, lat_min))});
         exp_req = exp_req + 32'd4;
         nreq++;
      end
      if (instr_valid_o && instr_ready_i && !redir) begin
         chk("instr_pc", instr_pc_o, exp_pc);
         chk("instr_data", instr_o, memf(exp_pc));
         exp_pc = exp_pc + 32'd4;
         npop++;
      end
      if (redir) begin
         exp_req = {rpc[31:2], 2'b00};
         exp_pc  = {rpc[31:2], 2'b00};
      end
      post_redir = redir;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) cycle(1'b0, 32'h0);
   endtask

   // Reset asserted at a falling edge; memory is reset alongside the DUT.
   task automatic do_reset();
      rst_n            = 1'b0;
      redirect_i       = 1'b0;
      redirect_pc_i    = '0;
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      instr_ready_i    = 1'b0;
      memq.delete();
      #1;
      chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_req_addr", imem_req_addr_o, RST_PC);
      repeat (2) @(negedge clk);
      rst_n      = 1'b1;
      exp_req    = RST_PC;
      exp_pc     = RST_PC;
      post_redir = 1'b0;
      @(negedge clk);
      chk("first_req_valid", 32'(imem_req_valid_o), 32'd1);
      chk("first_req_addr", imem_req_addr_o, RST_PC);
   endtask

   initial begin
      int p0;
      int r0;
      logic [31:0] rpc;
      rst_n            = 1'b1;
      redirect_i       = 1'b0;
      redirect_pc_i    = '0;
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      instr_ready_i    = 1'b0;
      exp_req          = RST_PC;
      exp_pc           = RST_PC;
      @(negedge clk);

      // Streaming at latency 1: PCs wrap FFFF_FFF8 -> FFFF_FFFC -> 0, one per cycle.
      do_reset();
      lat_min = 1; lat_max = 1; rdy_pct = 100; irdy_pct = 100;
      run(4);
      p0 = npop;
      run(20);
      chk("throughput", 32'(npop - p0), 32'd20);

      // Decode stalled at latency 3: exactly FIFO_DEPTH requests, then resume.
      do_reset();
      lat_min = 3; lat_max = 3; irdy_pct = 0;
      r0 = nreq;
      run(15);
      chk("stall_req_count", 32'(nreq - r0), 32'd4);
      chk("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
      chk("stall_head_pc", instr_pc_o, RST_PC);
      irdy_pct = 100;
      p0 = npop;
      run(20);
      chk("stall_resume_pops", 32'(npop - p0 >= 8), 32'd1);

      // Redirect to 0x100 with three requests in flight.
      do_reset();
      lat_min = 3; lat_max = 3; irdy_pct = 100;
      run(3);
      rdy_pct = 0;
      cycle(1'b1, 32'h100);
      rdy_pct = 100;
      p0 = npop;
      run(15);
      chk("redirect_delivered", 32'(npop > p0), 32'd1);

      // Redirect coinciding with request accept and response arrival; unaligned target.
      do_reset();
      lat_min = 1; lat_max = 1;
      run(6);
      r0 = nreq;
      cycle(1'b1, 32'h200);
      chk("redirect_with_accept", 32'(nreq - r0), 32'd1);
      p0 = npop;
      run(8);
      chk("redirect_same_cycle_pops", 32'(npop > p0), 32'd1);
      cycle(1'b1, 32'h103);
      p0 = npop;
      run(8);
      chk("unaligned_redirect_pops", 32'(npop > p0), 32'd1);

      // Reset asserted with the FIFO half full.
      do_reset();
      lat_min = 1; lat_max = 1; irdy_pct = 0;
      run(3);
      chk("half_full_valid", 32'(instr_valid_o), 32'd1);
      chk("half_full_head_pc", instr_pc_o, RST_PC);
      do_reset();
      irdy_pct = 100;
      p0 = npop;
      run(10);
      chk("restart_pops", 32'(npop > p0), 32'd1);

      // Random traffic: variable latency, backpressure both sides, random redirects.
      do_reset();
      lat_min = 1; lat_max = 4; rdy_pct = 70; irdy_pct = 70;
      p0 = npop;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 3) begin
            rpc = $urandom;
            if (rpc[4]) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
            cycle(1'b1, rpc);
         end else begin
            cycle(1'b0, 32'h0);
         end
      end
      chk("random_pops", 32'(npop - p0 > 300), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
